// File: rtl/ddr_rd_arbiter_if.sv
// Request/command bus of the four-way DDR read arbiter.
// The arbiter connects through the slave modport; the requesters and the
// DDR read channel connect through the master modport.
interface ddr_rd_arbiter_if #(
   parameter int ADDR_WIDTH   = 30,
   parameter int RD_NUM_WIDTH = 28
);
   logic [3:0]                  req_valid;
   logic [4*ADDR_WIDTH-1:0]     req_addr;
   logic [4*RD_NUM_WIDTH-1:0]   req_num;
   logic [3:0]                  req_done;
   logic                        ddr_rd_valid;
   logic [ADDR_WIDTH-1:0]       ddr_rd_addr;
   logic [RD_NUM_WIDTH-1:0]     ddr_rd_num;
   logic                        ddr_rd_done;
   logic                        busy;
   logic [1:0]                  grant_id;
   logic [3:0]                  err_overflow;
   logic                        err_spurious;

   modport slave (
      input  req_valid, req_addr, req_num, ddr_rd_done,
      output req_done, ddr_rd_valid, ddr_rd_addr, ddr_rd_num,
             busy, grant_id, err_overflow, err_spurious
   );

   modport master (
      output req_valid, req_addr, req_num, ddr_rd_done,
      input  req_done, ddr_rd_valid, ddr_rd_addr, ddr_rd_num,
             busy, grant_id, err_overflow, err_spurious
   );
endinterface

// File: rtl/ddr_rd_arbiter.sv
// Four-way round-robin arbiter in front of a single DDR read channel.
// Each requester pulses a request that is latched into a pending slot; the
// arbiter issues one command at a time and returns a done pulse to the
// requester once the DDR channel completes. Module parameters must match
// the parameters of the connected interface instance.
module ddr_rd_arbiter #(
   parameter int ADDR_WIDTH   = 30,
   parameter int RD_NUM_WIDTH = 28
) (
   input  logic             clk,
   input  logic             rst,
   ddr_rd_arbiter_if.slave  bus
);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t                   state_q, state_d;
   logic [3:0]               pending_q, pending_d;
   logic [1:0]               last_grant_q, last_grant_d;
   logic [1:0]               grant_id_q, grant_id_d;
   logic                     rd_valid_q, rd_valid_d;
   logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
   logic [RD_NUM_WIDTH-1:0]  rd_num_q, rd_num_d;
   logic [3:0]               req_done_q, req_done_d;
   logic [3:0]               err_ovf_q, err_ovf_d;
   logic                     err_spur_q, err_spur_d;

   logic [ADDR_WIDTH-1:0]    lat_addr_q [4];
   logic [RD_NUM_WIDTH-1:0]  lat_num_q  [4];

   logic                     win_found;
   logic [1:0]               win_id;
   logic [1:0]               scan_id;
   logic                     grant_fire;

   // Round-robin search: first pending requester after the last one served.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      win_found = 1'b0;
      win_id    = 2'd0;
      scan_id   = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         scan_id = last_grant_q + 2'(k);
         if (!win_found && pending_q[scan_id]) begin
            win_found = 1'b1;
            win_id    = scan_id;
         end
      end
   end

   assign grant_fire = (state_q == IDLE) && win_found;

   // Next state, pending bookkeeping, command/done outputs and error flags.
   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      rd_valid_d   = 1'b0;
      rd_addr_d    = rd_addr_q;
      rd_num_d     = rd_num_q;
      req_done_d   = 4'b0000;
      err_ovf_d    = err_ovf_q;
      err_spur_d   = err_spur_q;

      case (state_q)
         IDLE: begin
            if (bus.ddr_rd_done) err_spur_d = 1'b1;
            if (grant_fire) begin
               state_d    = WAIT;
               grant_id_d = win_id;
               rd_valid_d = 1'b1;
               rd_addr_d  = lat_addr_q[win_id];
               rd_num_d   = lat_num_q[win_id];
            end
         end
         WAIT: begin
            if (bus.ddr_rd_done) begin
               state_d      = IDLE;
               req_done_d   = 4'b0001 << grant_id_q;
               last_grant_d = grant_id_q;
            end
         end
         default: state_d = IDLE;
      endcase

      // A new request beats the clear of its own grant; it only counts as
      // an overwrite when the old request is still waiting to be served.
      for (int i = 0; i < 4; i++) begin
         if (bus.req_valid[i]) begin
            pending_d[i] = 1'b1;
            if (pending_q[i] && !(grant_fire && win_id == 2'(i)))
               err_ovf_d[i] = 1'b1;
         end else if (grant_fire && win_id == 2'(i)) begin
            pending_d[i] = 1'b0;
         end
      end
   end

   // State and control registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples values from before the edge.
      if (rst) begin
         state_q      <= IDLE;
         pending_q    <= 4'b0000;
         last_grant_q <= 2'd3;
         grant_id_q   <= 2'd0;
         rd_valid_q   <= 1'b0;
         rd_addr_q    <= '0;
         rd_num_q     <= '0;
         req_done_q   <= 4'b0000;
         err_ovf_q    <= 4'b0000;
         err_spur_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         rd_valid_q   <= rd_valid_d;
         rd_addr_q    <= rd_addr_d;
         rd_num_q     <= rd_num_d;
         req_done_q   <= req_done_d;
         err_ovf_q    <= err_ovf_d;
         err_spur_q   <= err_spur_d;
      end
   end

   // Per-requester address/count latches, captured on each request pulse.
   always_ff @(posedge clk) begin
      // NOTE: the latches carry no reset; a slot is only read after its
      // pending bit was set, which always writes the slot first.
      for (int i = 0; i < 4; i++) begin
         if (bus.req_valid[i]) begin
            lat_addr_q[i] <= bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            lat_num_q[i]  <= bus.req_num[i*RD_NUM_WIDTH +: RD_NUM_WIDTH];
         end
      end
   end

   assign bus.req_done     = req_done_q;
   assign bus.ddr_rd_valid = rd_valid_q;
   assign bus.ddr_rd_addr  = rd_addr_q;
   assign bus.ddr_rd_num   = rd_num_q;
   assign bus.busy         = (state_q == WAIT);
   assign bus.grant_id     = grant_id_q;
   assign bus.err_overflow = err_ovf_q;
   assign bus.err_spurious = err_spur_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed self-checking bench for ddr_rd_arbiter: single request latency,
// four-way round robin, fairness with re-requests, overwrite handling,
// spurious completion and reset during an outstanding command.
module tb_ddr_rd_arbiter;
   localparam int AW = 30;
   localparam int NW = 28;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   int   n_valid;
   int   cyc;

   ddr_rd_arbiter_if #(.ADDR_WIDTH(AW), .RD_NUM_WIDTH(NW)) bus ();

   ddr_rd_arbiter #(.ADDR_WIDTH(AW), .RD_NUM_WIDTH(NW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts command pulses, sampled mid-cycle.
   always @(negedge clk) if (bus.ddr_rd_valid === 1'b1) n_valid++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Advance one clock; outputs are stable and inputs may be driven afterwards.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [NW-1:0] n);
      bus.req_valid[i]             = 1'b1;
      bus.req_addr[i*AW +: AW]     = a;
      bus.req_num[i*NW +: NW]      = n;
   endtask

   // Waits (bounded) for a command pulse and checks what was granted.
   task automatic expect_grant(input logic [1:0] id, input logic [AW-1:0] a, input logic [NW-1:0] n);
      int k = 0;
      while (bus.ddr_rd_valid !== 1'b1 && k < 8) begin
         tick();
         k++;
      end
      chk("grant_seen", 64'(bus.ddr_rd_valid), 64'd1);
      chk("grant_id",   64'(bus.grant_id),     64'(id));
      chk("grant_addr", 64'(bus.ddr_rd_addr),  64'(a));
      chk("grant_num",  64'(bus.ddr_rd_num),   64'(n));
   endtask

   // Grant, then completion four cycles after the command; ends in the
   // cycle where req_done is visible.
   task automatic serve(input logic [1:0] id, input logic [AW-1:0] a, input logic [NW-1:0] n);
      expect_grant(id, a, n);
      tick();
      chk("valid_one_cycle", 64'(bus.ddr_rd_valid), 64'd0);
      chk("busy_in_wait",    64'(bus.busy),         64'd1);
      tick();
      tick();
      tick();
      bus.ddr_rd_done = 1'b1;
      tick();
      bus.ddr_rd_done = 1'b0;
      chk("req_done",        64'(bus.req_done),     64'(4'b0001 << id));
      chk("busy_after_done", 64'(bus.busy),         64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int base;
      n_checks = 0;
      n_pass   = 0;
      n_valid  = 0;
      cyc      = 0;
      rst      = 1'b1;
      bus.req_valid   = 4'b0000;
      bus.req_addr    = '0;
      bus.req_num     = '0;
      bus.ddr_rd_done = 1'b0;

      // Reset state
      tick();
      tick();
      rst = 1'b0;
      chk("rst_valid",    64'(bus.ddr_rd_valid), 64'd0);
      chk("rst_busy",     64'(bus.busy),         64'd0);
      chk("rst_done",     64'(bus.req_done),     64'd0);
      chk("rst_grant_id", 64'(bus.grant_id),     64'd0);
      chk("rst_addr",     64'(bus.ddr_rd_addr),  64'd0);
      chk("rst_num",      64'(bus.ddr_rd_num),   64'd0);
      chk("rst_ovf",      64'(bus.err_overflow), 64'd0);
      chk("rst_spur",     64'(bus.err_spurious), 64'd0);

      // Single request: command two cycles after the request pulse
      tick();
      set_req(2, 30'h0078_0000, 28'd512);
      tick();
      bus.req_valid = 4'b0000;
      chk("lat_not_early", 64'(bus.ddr_rd_valid), 64'd0);
      tick();
      chk("lat_valid",     64'(bus.ddr_rd_valid), 64'd1);
      chk("lat_addr",      64'(bus.ddr_rd_addr),  64'h0078_0000);
      chk("lat_num",       64'(bus.ddr_rd_num),   64'd512);
      chk("lat_grant_id",  64'(bus.grant_id),     64'd2);
      chk("lat_busy",      64'(bus.busy),         64'd1);
      for (int k = 0; k < 7; k++) tick();
      chk("held_addr",     64'(bus.ddr_rd_addr),  64'h0078_0000);
      chk("held_done_low", 64'(bus.req_done),     64'd0);
      bus.ddr_rd_done = 1'b1;
      tick();
      bus.ddr_rd_done = 1'b0;
      chk("single_done",   64'(bus.req_done),     64'h4);
      tick();
      chk("done_one_cycle", 64'(bus.req_done),    64'd0);

      // Simultaneous requests after reset: order 0,1,2,3
      do_reset();
      base = n_valid;
      for (int i = 0; i < 4; i++) set_req(i, 30'(32'h100 * (i + 1)), 28'(i + 1));
      tick();
      bus.req_valid = 4'b0000;
      for (int g = 0; g < 4; g++) serve(2'(g), 30'(32'h100 * (g + 1)), 28'(g + 1));
      for (int k = 0; k < 4; k++) tick();
      chk("rr_pulses", 64'(n_valid - base), 64'd4);

      // Fairness: 0,1,3 pending, 0 re-requests after its done -> 0,1,3,0
      base = n_valid;
      set_req(0, 30'h0000_0A00, 28'd10);
      set_req(1, 30'h0000_0B00, 28'd11);
      set_req(3, 30'h0000_0D00, 28'd13);
      tick();
      bus.req_valid = 4'b0000;
      serve(2'd0, 30'h0000_0A00, 28'd10);
      set_req(0, 30'h0000_0A40, 28'd20);
      tick();
      bus.req_valid = 4'b0000;
      serve(2'd1, 30'h0000_0B00, 28'd11);
      serve(2'd3, 30'h0000_0D00, 28'd13);
      serve(2'd0, 30'h0000_0A40, 28'd20);
      for (int k = 0; k < 4; k++) tick();
      chk("fair_pulses", 64'(n_valid - base), 64'd4);
      chk("fair_no_ovf", 64'(bus.err_overflow), 64'd0);

      // Overwrite: 1 requests A then B while 0 is in flight
      base = n_valid;
      set_req(0, 30'h0000_1000, 28'd1);
      tick();
      bus.req_valid = 4'b0000;
      expect_grant(2'd0, 30'h0000_1000, 28'd1);
      set_req(1, 30'h0000_AAA0, 28'd7);
      tick();
      bus.req_valid = 4'b0000;
      tick();
      set_req(1, 30'h0000_BBB0, 28'd8);
      tick();
      bus.req_valid = 4'b0000;
      chk("ovf_flag", 64'(bus.err_overflow), 64'h2);
      bus.ddr_rd_done = 1'b1;
      tick();
      bus.ddr_rd_done = 1'b0;
      chk("ovf_done0", 64'(bus.req_done), 64'h1);
      serve(2'd1, 30'h0000_BBB0, 28'd8);
      for (int k = 0; k < 5; k++) tick();
      chk("ovf_single_grant", 64'(n_valid - base), 64'd2);

      // Re-request on the requester's own grant edge: pends, no error
      set_req(2, 30'h0000_2000, 28'd3);
      tick();
      set_req(2, 30'h0000_2100, 28'd4);
      tick();
      bus.req_valid = 4'b0000;
      serve(2'd2, 30'h0000_2000, 28'd3);
      serve(2'd2, 30'h0000_2100, 28'd4);
      chk("same_edge_no_ovf", 64'(bus.err_overflow), 64'h2);

      // Spurious completion in IDLE
      tick();
      bus.ddr_rd_done = 1'b1;
      tick();
      bus.ddr_rd_done = 1'b0;
      chk("spur_flag",    64'(bus.err_spurious), 64'd1);
      chk("spur_no_done", 64'(bus.req_done),     64'd0);
      chk("spur_busy",    64'(bus.busy),         64'd0);

      // Reset during WAIT abandons the command
      do_reset();
      chk("rst2_spur", 64'(bus.err_spurious), 64'd0);
      chk("rst2_ovf",  64'(bus.err_overflow), 64'd0);
      set_req(3, 30'h0000_3000, 28'd9);
      tick();
      bus.req_valid = 4'b0000;
      expect_grant(2'd3, 30'h0000_3000, 28'd9);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_wait_busy", 64'(bus.busy), 64'd0);
      tick();
      bus.ddr_rd_done = 1'b1;
      tick();
      bus.ddr_rd_done = 1'b0;
      chk("rst_wait_no_done", 64'(bus.req_done),     64'd0);
      chk("rst_wait_spur",    64'(bus.err_spurious), 64'd1);
      chk("rst_wait_idle",    64'(bus.busy),         64'd0);
      tick();
      chk("rst_wait_no_done2", 64'(bus.req_done),    64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/ddr_rd_arbiter.md
DDR_RD_ARBITER -- requirements
Module: ddr_rd_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 30, meaning the DDR read byte-address width.
REQ-002 The block SHALL have parameter RD_NUM_WIDTH, default 28, meaning the burst-count width.
REQ-003 The block SHALL have a fixed requester count of 4; requester i uses bit/slice i of each vector.
REQ-004 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  4  one-cycle request pulse per requester.
REQ-007 req_addr  in  4*ADDR_WIDTH  request address; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 req_num  in  4*RD_NUM_WIDTH  request burst count; slice i = [i*RD_NUM_WIDTH +: RD_NUM_WIDTH].
REQ-009 req_done  out  4  one-cycle completion pulse to requester i.
REQ-010 ddr_rd_valid  out  1  one-cycle command pulse to the DDR read channel.
REQ-011 ddr_rd_addr  out  ADDR_WIDTH  granted address, held until the next grant.
REQ-012 ddr_rd_num  out  RD_NUM_WIDTH  granted count, held until the next grant.
REQ-013 ddr_rd_done  in  1  one-cycle completion pulse from the DDR read channel.
REQ-014 busy  out  1  high while a command is outstanding.
REQ-015 grant_id  out  2  index of the current/last granted requester.
REQ-016 err_overflow  out  4  sticky per-requester overwrite flag.
REQ-017 err_spurious  out  1  sticky flag for ddr_rd_done with no command outstanding.

Function
REQ-018 Each requester SHALL have a pending bit plus a latched addr/num; req_valid[i] at edge E sets pending[i] and captures req_addr/req_num slice i.
REQ-019 The FSM SHALL have two states, IDLE and WAIT.
REQ-020 IDLE with pending nonzero: at the next edge the block SHALL grant by round-robin, starting at (last_grant+1) mod 4.
REQ-021 On that grant edge, the block SHALL load ddr_rd_addr/ddr_rd_num from the winner's latch, set grant_id, pulse ddr_rd_valid for exactly one cycle, clear pending[winner], and enter WAIT.
REQ-022 Minimum latency: req_valid high in cycle N with the arbiter idle SHALL give ddr_rd_valid high in cycle N+2.
REQ-023 In WAIT, ddr_rd_done SHALL cause req_done[grant_id] high for exactly the next cycle, last_grant<=grant_id, and a return to IDLE.
REQ-024 The first new grant after completion SHALL be no earlier than the cycle after req_done; the arbiter SHALL never back-to-back issue within the same cycle.
REQ-025 busy SHALL be high exactly while in WAIT.
REQ-026 req_valid[i] on the same edge pending[i] is cleared by a grant: the new request SHALL win, so pending[i] stays set with the new addr/num; err_overflow SHALL NOT be set.
REQ-027 req_valid[i] while pending[i] is set and i is not being granted: the latch SHALL be overwritten with the new values and err_overflow[i] set.
REQ-028 req_valid[i] while requester i is the one in flight SHALL pend normally, with no error.
REQ-029 ddr_rd_done in IDLE SHALL be ignored apart from setting err_spurious.
REQ-030 ddr_rd_done and a new req_valid in the same cycle SHALL both take effect.
REQ-031 Requests SHALL never be dropped.
REQ-032 Round-robin SHALL bound the wait to 3 other grants.

Reset
REQ-033 rst SHALL clear pending, req_done, ddr_rd_valid, busy, err_overflow and err_spurious, and set state to IDLE.
REQ-034 rst SHALL set ddr_rd_addr, ddr_rd_num and grant_id to 0, and last_grant to 3, so requester 0 has first priority.
REQ-035 rst asserted mid-WAIT SHALL abandon the outstanding command; no req_done SHALL follow, and a later ddr_rd_done SHALL set err_spurious.
REQ-036 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-037 Single request: req_valid=4'b0100, addr slice 2=0x0078_0000, num slice 2=512 at cycle 10 -> ddr_rd_valid at cycle 12 with addr 0x0078_0000 and num 512, grant_id=2; ddr_rd_done at 20 -> req_done=4'b0100 at 21.
REQ-038 Simultaneous requests: req_valid=4'b1111 at cycle 5, with done returned 4 cycles after each command -> grant order 0,1,2,3 and one req_done pulse each.
REQ-039 Fairness: requester 0 re-requests immediately after each of its req_done while 1 and 3 stay pending -> grant order 0,1,3,0, with no starvation.
REQ-040 Overwrite: req_valid[1] with addr A, then req_valid[1] with addr B while 0 is in flight -> a single grant to 1 with addr B, and err_overflow=4'b0010.
REQ-041 Boundary: ddr_rd_done pulsed in IDLE -> err_spurious=1 with no req_done; rst during WAIT then ddr_rd_done -> no req_done, busy=0.
